// File: rtl/hand_pkg.sv
// Shared types, constants and card-point decode for the baccarat hand scorer.
package hand_pkg;

  typedef logic [3:0] card_t;
  typedef logic [3:0] score_t;

  localparam card_t       CARD_MIN = 4'd1;
  localparam card_t       CARD_MAX = 4'd13;
  localparam int unsigned MOD      = 10;
  // Worst-case score + points is 9 + 9 = 18, which needs 5 bits.
  localparam int unsigned SUM_W    = 5;

  // Baccarat points: Ace..9 count face value, 10..King count zero.
  function automatic score_t card_points(input card_t c);
    score_t p;
    if (c >= CARD_MIN && c <= 4'd9) p = score_t'(c);
    else                            p = '0;
    return p;
  endfunction

endpackage

// File: rtl/hand_compare.sv
// Combinational leader search over packed 4-bit hand scores.
//   scores   : hand h score at [4h+3:4h]
//   leader_c : lowest index among the hands holding the maximum score
//   tie_c    : two or more hands share the maximum score
module hand_compare
  import hand_pkg::*;
#(
  parameter  int unsigned NUM_HANDS = 2,
  localparam int unsigned HW        = $clog2(NUM_HANDS)
) (
  input  logic [NUM_HANDS*4-1:0] scores,
  output logic [HW-1:0]          leader_c,
  output logic                   tie_c
);

  score_t max_s;

  // Strict '>' keeps the lowest index on equal scores; any other hand at max is a tie.
  always_comb begin
    max_s    = scores[3:0];
    leader_c = '0;
    tie_c    = 1'b0;
    for (int unsigned h = 1; h < NUM_HANDS; h++) begin
      if (scores[4*h +: 4] > max_s) begin
        max_s    = scores[4*h +: 4];
        leader_c = HW'(h);
      end
    end
    for (int unsigned h = 0; h < NUM_HANDS; h++) begin
      if (scores[4*h +: 4] == max_s && HW'(h) != leader_c) tie_c = 1'b1;
    end
  end

endmodule

// File: rtl/hand_accumulator.sv
// Multi-hand baccarat scorer: takes one card per cycle, keeps per-hand mod-10
// score and card count, and registers the leading hand and tie status.
//   slow_clock : clock, all state on rising edge
//   resetb     : synchronous active-low reset
//   clear      : start a new round (zeroes hands and err; beats a same-cycle card)
//   card_valid : a card is presented this cycle
//   card_hand  : target hand index
//   card       : card code, 1 = Ace .. 13 = King
//   card_ack   : combinational, card accepted this cycle
//   score      : packed mod-10 scores, hand h at [4h+3:4h]
//   count      : packed card counts, hand h at [CW*h+CW-1:CW*h]
//   full       : hand holds MAX_CARDS cards
//   natural    : hand holds two cards scoring 8 or 9
//   leader     : registered index of highest-scoring hand (lowest index on ties)
//   tie        : registered, two or more hands share the highest score
//   err        : sticky, a presented card was rejected
module hand_accumulator
  import hand_pkg::*;
#(
  parameter  int unsigned NUM_HANDS = 2,
  parameter  int unsigned MAX_CARDS = 3,
  localparam int unsigned HW        = $clog2(NUM_HANDS),
  localparam int unsigned CW        = $clog2(MAX_CARDS + 1)
) (
  input  logic                      slow_clock,
  input  logic                      resetb,
  input  logic                      clear,
  input  logic                      card_valid,
  input  logic [HW-1:0]             card_hand,
  input  logic [3:0]                card,
  output logic                      card_ack,
  output logic [NUM_HANDS*4-1:0]    score,
  output logic [NUM_HANDS*CW-1:0]   count,
  output logic [NUM_HANDS-1:0]      full,
  output logic [NUM_HANDS-1:0]      natural,
  output logic [HW-1:0]             leader,
  output logic                      tie,
  output logic                      err
);

  score_t              score_q [NUM_HANDS];
  logic [CW-1:0]       count_q [NUM_HANDS];
  logic [NUM_HANDS-1:0] hit;
  logic                card_ok;
  logic                room;
  score_t              sel_score;
  score_t              pts;
  logic [SUM_W-1:0]    sum;
  score_t              score_nxt;
  logic [HW-1:0]       leader_c;
  logic                tie_c;

  // Target-hand decode; an out-of-range index matches no hand and so has no room.
  always_comb begin
    hit = '0;
    for (int unsigned h = 0; h < NUM_HANDS; h++) hit[h] = (card_hand == HW'(h));
    card_ok  = (card >= CARD_MIN) && (card <= CARD_MAX);
    room     = |(hit & ~full);
    card_ack = card_valid & ~clear & card_ok & room;
  end

  // One shared adder: only the targeted hand can change in a given cycle.
  always_comb begin
    sel_score = '0;
    for (int unsigned h = 0; h < NUM_HANDS; h++) begin
      if (hit[h]) sel_score = score_q[h];
    end
    pts       = card_points(card);
    sum       = SUM_W'(sel_score) + SUM_W'(pts);
    score_nxt = (sum >= SUM_W'(MOD)) ? score_t'(sum - SUM_W'(MOD)) : score_t'(sum);
  end

  // Flatten per-hand registers and decode status flags.
  always_comb begin
    score   = '0;
    count   = '0;
    full    = '0;
    natural = '0;
    for (int unsigned h = 0; h < NUM_HANDS; h++) begin
      score[4*h +: 4]   = score_q[h];
      count[CW*h +: CW] = count_q[h];
      full[h]           = (count_q[h] == CW'(MAX_CARDS));
      natural[h]        = (count_q[h] == CW'(2)) && (score_q[h] >= score_t'(8));
    end
  end

  hand_compare #(
    .NUM_HANDS (NUM_HANDS)
  ) u_compare (
    .scores   (score),
    .leader_c (leader_c),
    .tie_c    (tie_c)
  );

  // Hand state, sticky error and the one-stage comparator pipeline.
  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      for (int unsigned h = 0; h < NUM_HANDS; h++) begin
        score_q[h] <= '0;
        count_q[h] <= '0;
      end
      err    <= 1'b0;
      leader <= '0;
      tie    <= 1'b1;
    end else begin
      leader <= leader_c;
      tie    <= tie_c;
      if (clear) begin
        for (int unsigned h = 0; h < NUM_HANDS; h++) begin
          score_q[h] <= '0;
          count_q[h] <= '0;
        end
        err <= 1'b0;
      end else begin
        if (card_ack) begin
          for (int unsigned h = 0; h < NUM_HANDS; h++) begin
            if (hit[h]) begin
              score_q[h] <= score_nxt;
              count_q[h] <= count_q[h] + CW'(1);
            end
          end
        end
        if (card_valid && !card_ack) err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hand_accumulator.sv
// Scoreboard bench for hand_accumulator with three parameterisations:
//   a: 2 hands x 3 cards, b: 4 hands x 5 cards, c: 3 hands x 2 cards.
module tb_hand_accumulator;

  typedef struct {
    int inst;
    int hand;
    int score;
    int count;
  } exp_t;

  logic slow_clock = 1'b0;
  always #5 slow_clock = ~slow_clock;

  logic       resetb = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] card = 4'd0;
  logic       valid_a = 1'b0, valid_b = 1'b0, valid_c = 1'b0;
  logic [0:0] hand_a = '0;
  logic [1:0] hand_b = '0, hand_c = '0;

  logic        ack_a, ack_b, ack_c;
  logic [7:0]  score_a;  logic [15:0] score_b;  logic [11:0] score_c;
  logic [3:0]  count_a;  logic [11:0] count_b;  logic [5:0]  count_c;
  logic [1:0]  full_a, nat_a;
  logic [3:0]  full_b, nat_b;
  logic [2:0]  full_c, nat_c;
  logic [0:0]  leader_a; logic [1:0] leader_b, leader_c;
  logic        tie_a, tie_b, tie_c, err_a, err_b, err_c;

  hand_accumulator #(.NUM_HANDS(2), .MAX_CARDS(3)) dut_a (
    .slow_clock(slow_clock), .resetb(resetb), .clear(clear), .card_valid(valid_a),
    .card_hand(hand_a), .card(card), .card_ack(ack_a), .score(score_a), .count(count_a),
    .full(full_a), .natural(nat_a), .leader(leader_a), .tie(tie_a), .err(err_a));

  hand_accumulator #(.NUM_HANDS(4), .MAX_CARDS(5)) dut_b (
    .slow_clock(slow_clock), .resetb(resetb), .clear(clear), .card_valid(valid_b),
    .card_hand(hand_b), .card(card), .card_ack(ack_b), .score(score_b), .count(count_b),
    .full(full_b), .natural(nat_b), .leader(leader_b), .tie(tie_b), .err(err_b));

  hand_accumulator #(.NUM_HANDS(3), .MAX_CARDS(2)) dut_c (
    .slow_clock(slow_clock), .resetb(resetb), .clear(clear), .card_valid(valid_c),
    .card_hand(hand_c), .card(card), .card_ack(ack_c), .score(score_c), .count(count_c),
    .full(full_c), .natural(nat_c), .leader(leader_c), .tie(tie_c), .err(err_c));

  int checks = 0;
  int errors = 0;
  int nh [3] = '{2, 4, 3};
  int mx [3] = '{3, 5, 2};
  int ms [3][4];
  int mc [3][4];
  bit merr [3];
  exp_t q [$];

  // Reference model helpers
  function automatic int pts_of(input int c);
    return (c >= 1 && c <= 9) ? c : 0;
  endfunction

  function automatic void model_zero(input bit with_err);
    for (int i = 0; i < 3; i++) begin
      for (int h = 0; h < 4; h++) begin ms[i][h] = 0; mc[i][h] = 0; end
      if (with_err) merr[i] = 1'b0;
    end
  endfunction

  // DUT output accessors by instance
  function automatic logic d_ack(input int i);
    case (i) 0: return ack_a; 1: return ack_b; default: return ack_c; endcase
  endfunction
  function automatic logic [31:0] d_score(input int i, input int h);
    case (i)
      0: return 32'(score_a[4*h +: 4]);
      1: return 32'(score_b[4*h +: 4]);
      default: return 32'(score_c[4*h +: 4]);
    endcase
  endfunction
  function automatic logic [31:0] d_count(input int i, input int h);
    case (i)
      0: return 32'(count_a[2*h +: 2]);
      1: return 32'(count_b[3*h +: 3]);
      default: return 32'(count_c[2*h +: 2]);
    endcase
  endfunction
  function automatic logic d_full(input int i, input int h);
    case (i) 0: return full_a[h]; 1: return full_b[h]; default: return full_c[h]; endcase
  endfunction
  function automatic logic d_nat(input int i, input int h);
    case (i) 0: return nat_a[h]; 1: return nat_b[h]; default: return nat_c[h]; endcase
  endfunction
  function automatic logic [31:0] d_leader(input int i);
    case (i) 0: return 32'(leader_a); 1: return 32'(leader_b); default: return 32'(leader_c); endcase
  endfunction
  function automatic logic d_tie(input int i);
    case (i) 0: return tie_a; 1: return tie_b; default: return tie_c; endcase
  endfunction
  function automatic logic d_err(input int i);
    case (i) 0: return err_a; 1: return err_b; default: return err_c; endcase
  endfunction

  // Present one card to instance i for one cycle; score the result after the edge.
  task automatic drive(input int i, input int h, input int c);
    bit   exp_ack;
    exp_t e;
    int   ws, wc;
    @(negedge slow_clock);
    card = 4'(c);
    case (i)
      0: begin hand_a = 1'(h); valid_a = 1'b1; end
      1: begin hand_b = 2'(h); valid_b = 1'b1; end
      default: begin hand_c = 2'(h); valid_c = 1'b1; end
    endcase
    exp_ack = (h < nh[i]) && (c >= 1) && (c <= 13) && (mc[i][h] < mx[i]);
    #1;
    checks++;
    if (d_ack(i) !== exp_ack) begin
      errors++;
      $display("FAIL ack inst%0d hand%0d card%0d: got %b want %b", i, h, c, d_ack(i), exp_ack);
    end
    if (exp_ack) begin
      ms[i][h] = (ms[i][h] + pts_of(c)) % 10;
      mc[i][h] = mc[i][h] + 1;
      q.push_back('{i, h, ms[i][h], mc[i][h]});
    end else begin
      merr[i] = 1'b1;
    end
    @(posedge slow_clock);
    #1;
    valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
    if (q.size() != 0) begin
      e = q.pop_front();
    end else begin
      e = '{i, (h < nh[i]) ? h : 0, 0, 0};
      e.score = ms[i][e.hand];
      e.count = mc[i][e.hand];
    end
    ws = e.score; wc = e.count;
    checks += 4;
    if (d_score(e.inst, e.hand) !== 32'(ws)) begin
      errors++;
      $display("FAIL score inst%0d hand%0d: got %0d want %0d", e.inst, e.hand, d_score(e.inst, e.hand), ws);
    end
    if (d_count(e.inst, e.hand) !== 32'(wc)) begin
      errors++;
      $display("FAIL count inst%0d hand%0d: got %0d want %0d", e.inst, e.hand, d_count(e.inst, e.hand), wc);
    end
    if (d_full(e.inst, e.hand) !== (wc == mx[e.inst])) begin
      errors++;
      $display("FAIL full inst%0d hand%0d: got %b want %b", e.inst, e.hand, d_full(e.inst, e.hand), wc == mx[e.inst]);
    end
    if (d_nat(e.inst, e.hand) !== (wc == 2 && ws >= 8)) begin
      errors++;
      $display("FAIL natural inst%0d hand%0d: got %b want %b", e.inst, e.hand, d_nat(e.inst, e.hand), wc == 2 && ws >= 8);
    end
    checks++;
    if (d_err(i) !== merr[i]) begin
      errors++;
      $display("FAIL err inst%0d: got %b want %b", i, d_err(i), merr[i]);
    end
  endtask

  // Idle one cycle so the comparator stage catches up, then check leader/tie.
  task automatic check_leader(input int i);
    int best, lead, n;
    @(posedge slow_clock);
    #1;
    best = -1; lead = 0; n = 0;
    for (int h = 0; h < nh[i]; h++) if (ms[i][h] > best) begin best = ms[i][h]; lead = h; end
    for (int h = 0; h < nh[i]; h++) if (ms[i][h] == best) n++;
    checks += 2;
    if (d_leader(i) !== 32'(lead)) begin
      errors++;
      $display("FAIL leader inst%0d: got %0d want %0d", i, d_leader(i), lead);
    end
    if (d_tie(i) !== (n >= 2)) begin
      errors++;
      $display("FAIL tie inst%0d: got %b want %b", i, d_tie(i), n >= 2);
    end
  endtask

  // Reset, optionally with a card presented to b in the same cycle.
  task automatic test_reset(input bit mid_round);
    @(negedge slow_clock);
    resetb = 1'b0;
    if (mid_round) begin card = 4'd9; hand_b = 2'd2; valid_b = 1'b1; end
    @(posedge slow_clock);
    #1;
    valid_b = 1'b0;
    model_zero(1'b1);
    q.delete();
    for (int i = 0; i < 3; i++) begin
      for (int h = 0; h < nh[i]; h++) begin
        checks++;
        if (d_score(i, h) !== 32'd0 || d_count(i, h) !== 32'd0 || d_full(i, h) !== 1'b0 || d_nat(i, h) !== 1'b0) begin
          errors++;
          $display("FAIL reset_hand inst%0d hand%0d: score %0d count %0d full %b nat %b want all 0",
                   i, h, d_score(i, h), d_count(i, h), d_full(i, h), d_nat(i, h));
        end
      end
      checks += 3;
      if (d_leader(i) !== 32'd0) begin
        errors++; $display("FAIL reset_leader inst%0d: got %0d want 0", i, d_leader(i));
      end
      if (d_tie(i) !== 1'b1) begin
        errors++; $display("FAIL reset_tie inst%0d: got %b want 1", i, d_tie(i));
      end
      if (d_err(i) !== 1'b0) begin
        errors++; $display("FAIL reset_err inst%0d: got %b want 0", i, d_err(i));
      end
    end
    @(negedge slow_clock);
    resetb = 1'b1;
  endtask

  // Clear all instances; optionally race a card into instance i (it must be dropped).
  task automatic test_clear(input int i, input bit with_card);
    @(negedge slow_clock);
    clear = 1'b1;
    if (with_card) begin
      card = 4'd5;
      case (i) 0: begin hand_a = 1'b0; valid_a = 1'b1; end
               1: begin hand_b = 2'd0; valid_b = 1'b1; end
               default: begin hand_c = 2'd0; valid_c = 1'b1; end
      endcase
    end
    #1;
    checks++;
    if (d_ack(i) !== 1'b0) begin
      errors++; $display("FAIL clear_ack inst%0d: got %b want 0", i, d_ack(i));
    end
    @(posedge slow_clock);
    #1;
    clear = 1'b0; valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
    model_zero(1'b1);
    for (int h = 0; h < nh[i]; h++) begin
      checks++;
      if (d_score(i, h) !== 32'd0 || d_count(i, h) !== 32'd0) begin
        errors++;
        $display("FAIL clear_hand inst%0d hand%0d: score %0d count %0d want 0 0", i, h, d_score(i, h), d_count(i, h));
      end
    end
    checks++;
    if (d_err(i) !== 1'b0) begin
      errors++; $display("FAIL clear_err inst%0d: got %b want 0", i, d_err(i));
    end
    check_leader(i);
  endtask

  task automatic test_basic();
    drive(0, 0, 2); drive(0, 0, 3); drive(0, 0, 1);
    drive(0, 1, 10); drive(0, 1, 11);
    check_leader(0);
  endtask

  task automatic test_natural();
    test_clear(0, 1'b0);
    drive(0, 1, 4); drive(0, 1, 5); drive(0, 1, 12);
    check_leader(0);
  endtask

  task automatic test_wrap_full();
    test_clear(0, 1'b0);
    drive(0, 0, 7); drive(0, 0, 8); drive(0, 0, 1);
    drive(0, 0, 5);
    check_leader(0);
  endtask

  task automatic test_invalid();
    drive(0, 1, 0); drive(0, 1, 14); drive(0, 1, 15);
    drive(2, 3, 5);
    drive(2, 0, 9); drive(2, 0, 9); drive(2, 0, 1);
    drive(2, 2, 13);
    check_leader(2);
    test_clear(0, 1'b1);
  endtask

  task automatic test_tie();
    drive(1, 1, 3); drive(1, 3, 2); drive(1, 1, 4); drive(1, 3, 5);
    drive(1, 0, 1); drive(1, 2, 6);
    check_leader(1);
  endtask

  task automatic test_back_to_back();
    test_clear(1, 1'b0);
    for (int k = 0; k < 30; k++) drive(1, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
    check_leader(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset(1'b0);
    test_basic();
    test_natural();
    test_wrap_full();
    test_invalid();
    test_tie();
    test_back_to_back();
    drive(1, 1, 8); drive(1, 2, 3);
    test_reset(1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
